axis_uart_emitter: RTL and testbench
====================================

Name: axis_uart_emitter

Overview:
- Hardware successor to the CPU-driven bit-banged UART path: AXI-Stream characters in, asynchronous serial frames out on a single TX line.
- Sits between a character source (e.g. a core-status stream) and the board UART pin.
- Adds what the software emitter lacks: an input FIFO, a runtime baud divisor, configurable data, parity and stop bits, and optional end-of-line injection on tlast.

Parameters:
- DATA_BITS, 8, character width, 5..9; sets i_tdata width.
- DEPTH, 8, FIFO entries, power of 2, >=2.
- DIV_W, 16, width of i_divisor.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, 1 or 2.
- APPEND_EOL, 0, 1 = send EOL_CHAR after every character accepted with tlast.
- EOL_CHAR, 8'h0A, injected character; truncated to its DATA_BITS LSBs.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_tdata  in  DATA_BITS  character.
- i_tlast  in  1  end-of-line marker for this character.
- i_tvalid  in  1  source has a character.
- o_tready  out  1  block can accept a character.
- i_divisor  in  DIV_W  bit period minus 1, in clocks.
- o_uart_tx  out  1  serial line, idle high.
- o_busy  out  1  frame in progress.
- o_fifo_level  out  $clog2(DEPTH)+1  occupied FIFO entries, 0..DEPTH.

Behaviour:
- Reset:
  - Asynchronous assert: o_uart_tx=1, o_busy=0, o_fifo_level=0, o_tready=0, FIFO flushed, FSM=IDLE, all counters 0.
  - o_tready goes 1 at the first rising edge after i_rst_n rises.
  - Reset mid-frame aborts the frame immediately; the line returns high in the same cycle, with no clock required.
- Input handshake:
  - A transfer occurs on a rising edge with i_tvalid & o_tready.
  - FIFO stores {tlast, tdata}.
  - o_tready is registered and equals !full. A simultaneous pop does not enable a push when full.
  - Order is preserved; no drops or duplicates.
- FSM states: IDLE, START, DATA, PARITY, STOP, then back to IDLE or straight to START.
- IDLE:
  - o_uart_tx=1.
  - If the FIFO is non-empty: pop into the shift register, latch i_divisor and the entry's tlast, and go to START.
- Bit timing:
  - Each bit lasts i_divisor+1 clocks, so divisor 0 gives 1 clock per bit.
  - The divisor is latched at frame start. Changes mid-frame take effect on the next frame only.
- Latency: for a character accepted at edge E0 with the FSM idle, o_uart_tx goes low after edge E0+2.
- START: line 0 for one bit period.
- DATA: DATA_BITS bits, LSB first.
- PARITY (present only if PARITY != 0):
  - Even mode: bit = XOR of data bits.
  - Odd mode: bit = inverted XOR of data bits.
- STOP: line 1 for STOP_BITS bit periods.
- End of STOP, in priority order:
  1. If APPEND_EOL=1, the latched tlast=1, and the current frame is not itself the EOL frame: load EOL_CHAR and go to START. The EOL frame carries no tlast and is never followed by another EOL.
  2. Else, if the FIFO is non-empty: pop and go to START with no idle gap.
  3. Else: go to IDLE.
- Frame length: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) × (divisor+1) clocks.
- o_busy = 1 in every state except IDLE.
- Capacity: up to DEPTH characters buffered plus one in the shift register.

Test Plan:
1. Config 8N1, i_divisor=3, send 0x55 → line low 4 clocks, then data bits 1,0,1,0,1,0,1,0 (4 clocks each), then high 4 clocks. Frame totals 40 clocks, o_busy high for exactly 40 cycles, start bit begins 2 edges after the handshake.
2. DEPTH=4, i_tvalid held high with 10 distinct characters, i_divisor=0 → o_fifo_level never exceeds 4 and o_tready drops while full. All 10 frames emerge in order, back-to-back with no idle cycles, 10 clocks each.
3. DATA_BITS=7 with PARITY=2, then PARITY=1, send 0x41 → parity bit 0 (even), then 1 (odd). Frame length is 10 bits × (divisor+1) clocks.
4. APPEND_EOL=1, EOL_CHAR=0x0A: send 0x31 with tlast=1, then 0x32 with tlast=0 → frames 0x31, 0x0A, 0x32 contiguous. With APPEND_EOL=0 the output is only 0x31, 0x32.
5. Pull i_rst_n low during the third data bit → o_uart_tx=1, o_busy=0, o_fifo_level=0, o_tready=0 with no clock edge. After release, o_tready=1 after one edge and the next character transmits intact.
6. Change i_divisor from 3 to 1 mid-frame → the current frame keeps 4-clock bits and the next frame uses 2-clock bits.

Source files
------------

// File: rtl/axis_uart_emitter.sv
// axis_uart_emitter: AXI-Stream characters in, asynchronous serial frames out.
// A small FIFO buffers {tlast, tdata}. A framing FSM sends start, data (LSB
// first), optional parity and stop bits, then optionally injects an EOL
// character after any character that arrived with tlast.
//
// Input handshake: a character transfers on a rising edge where
// i_tvalid && o_tready. o_tready is registered and is low only while the FIFO
// is full. A pop in the same cycle does not reopen it for a push.
module axis_uart_emitter #(
  parameter int         DATA_BITS  = 8,
  parameter int         DEPTH      = 8,
  parameter int         DIV_W      = 16,
  parameter int         PARITY     = 0,
  parameter int         STOP_BITS  = 1,
  parameter int         APPEND_EOL = 0,
  parameter logic [8:0] EOL_CHAR   = 9'h00A
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [DATA_BITS-1:0]   i_tdata,
  input  logic                   i_tlast,
  input  logic                   i_tvalid,
  output logic                   o_tready,
  input  logic [DIV_W-1:0]       i_divisor,
  output logic                   o_uart_tx,
  output logic                   o_busy,
  output logic [$clog2(DEPTH):0] o_fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0]        FULL_LVL  = LW'(DEPTH);
  localparam logic [DATA_BITS-1:0] EOL_W     = EOL_CHAR[DATA_BITS-1:0];
  localparam logic [3:0]           LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]           LAST_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  // FIFO state
  logic [DATA_BITS:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      count_q, count_d;
  logic               tready_q, tready_d;
  logic               push, pop, fifo_empty;
  logic [DATA_BITS:0] head;

  // Framing state
  state_e               state_q, state_d;
  logic [DIV_W-1:0]     cnt_q, cnt_d, div_q, div_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d, last_q, last_d, eol_q, eol_d, tx_q, tx_d;
  logic                 tick, load_en, load_last, load_eol;
  logic [DATA_BITS-1:0] load_data;

  assign push       = i_tvalid & tready_q;
  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];
  assign tick       = (cnt_q == div_q);

  // FIFO pointer and occupancy bookkeeping; ready tracks the next occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + LW'(1);
    else if (!push && pop) count_d = count_q - LW'(1);
    tready_d = (count_d != FULL_LVL);
  end

  // Storage array; occupancy lives in the pointers, so no reset is needed
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= {i_tlast, i_tdata};
  end

  // Framing FSM: next state, bit timing and frame loading
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_d     = par_q;
    last_d    = last_q;
    eol_d     = eol_q;
    pop       = 1'b0;
    load_en   = 1'b0;
    load_data = head[DATA_BITS-1:0];
    load_last = head[DATA_BITS];
    load_eol  = 1'b0;
    cnt_d     = tick ? '0 : cnt_q + DIV_W'(1);
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          load_en = 1'b1;
        end
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == LAST_DATA) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          state_d = S_STOP;
          bit_d   = '0;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (bit_q != LAST_STOP) begin
            bit_d = bit_q + 4'd1;
          end else if (APPEND_EOL != 0 && last_q && !eol_q) begin
            // The EOL frame carries no tlast, so it can never chain another EOL
            load_en   = 1'b1;
            load_data = EOL_W;
            load_last = 1'b0;
            load_eol  = 1'b1;
          end else if (!fifo_empty) begin
            pop     = 1'b1;
            load_en = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load_en) begin
      state_d = S_START;
      cnt_d   = '0;
      bit_d   = '0;
      div_d   = i_divisor;
      shift_d = load_data;
      par_d   = (PARITY == 1) ? ~(^load_data) : (^load_data);
      last_d  = load_last;
      eol_d   = load_eol;
    end
  end

  // Line level is registered from the current state, one cycle behind it
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_q[0];
      S_PARITY: tx_d = par_q;
      default:  tx_d = 1'b1;
    endcase
  end

  // State registers; reset drives the line high and flushes the FIFO
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tready_q <= 1'b0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      div_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      last_q   <= 1'b0;
      eol_q    <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      tready_q <= tready_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      last_q   <= last_d;
      eol_q    <= eol_d;
      tx_q     <= tx_d;
    end
  end

  assign o_tready     = tready_q;
  assign o_uart_tx    = tx_q;
  assign o_busy       = (state_q != S_IDLE);
  assign o_fifo_level = count_q;

endmodule

// File: tb/tb_axis_uart_emitter.sv
// Bench for axis_uart_emitter: three configurations share one clock.
//   k=0: 8N1, DEPTH 4, no EOL    k=1: 7E1, DEPTH 8, EOL 0x0A    k=2: 7O2, DEPTH 2
module tb_axis_uart_emitter;

  localparam int DB[3]     = '{8, 7, 7};
  localparam int PAR[3]    = '{0, 2, 1};
  localparam int STOP[3]   = '{1, 1, 2};
  localparam int EOL_ON[3] = '{0, 1, 0};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [8:0]  tdata_r [3];
  logic [2:0]  tlast_r, tvalid_r;
  logic [15:0] div_r [3];
  logic [2:0]  tready_w, tx_w, busy_w;
  logic [2:0]  lvl0;
  logic [3:0]  lvl1;
  logic [1:0]  lvl2;

  axis_uart_emitter #(.DATA_BITS(8), .DEPTH(4), .DIV_W(16), .PARITY(0), .STOP_BITS(1),
                      .APPEND_EOL(0), .EOL_CHAR(9'h00A)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_tdata(tdata_r[0][7:0]), .i_tlast(tlast_r[0]),
    .i_tvalid(tvalid_r[0]), .o_tready(tready_w[0]), .i_divisor(div_r[0]),
    .o_uart_tx(tx_w[0]), .o_busy(busy_w[0]), .o_fifo_level(lvl0));

  axis_uart_emitter #(.DATA_BITS(7), .DEPTH(8), .DIV_W(16), .PARITY(2), .STOP_BITS(1),
                      .APPEND_EOL(1), .EOL_CHAR(9'h00A)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_tdata(tdata_r[1][6:0]), .i_tlast(tlast_r[1]),
    .i_tvalid(tvalid_r[1]), .o_tready(tready_w[1]), .i_divisor(div_r[1]),
    .o_uart_tx(tx_w[1]), .o_busy(busy_w[1]), .o_fifo_level(lvl1));

  axis_uart_emitter #(.DATA_BITS(7), .DEPTH(2), .DIV_W(16), .PARITY(1), .STOP_BITS(2),
                      .APPEND_EOL(0), .EOL_CHAR(9'h00A)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_tdata(tdata_r[2][6:0]), .i_tlast(tlast_r[2]),
    .i_tvalid(tvalid_r[2]), .o_tready(tready_w[2]), .i_divisor(div_r[2]),
    .o_uart_tx(tx_w[2]), .o_busy(busy_w[2]), .o_fifo_level(lvl2));

  // ---------------- scoreboard state ----------------
  logic [10:0] exp_q[$];          // {instance, character} in expected line order
  int n_checks = 0;
  int n_fail   = 0;
  int hs_cyc   = 0;               // edge number of the last handshake
  int mon_frames[3] = '{0, 0, 0};
  int gap_sum[3]    = '{0, 0, 0};
  bit seen[3]       = '{0, 0, 0};
  int start_cyc[3]  = '{0, 0, 0};
  bit track = 1'b0;
  int lvl_viol = 0;
  bit full_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int frame_bits(input int k);
    return 1 + DB[k] + ((PAR[k] != 0) ? 1 : 0) + STOP[k];
  endfunction

  // ---------------- line monitor / decoder ----------------
  // Decodes frames from the line using the divisor the bench applied at the
  // start bit, checks every clock of every bit, and pops the expected queue.
  task automatic monitor(input int k);
    logic [15:0] val;
    logic [8:0]  ch;
    logic [10:0] e;
    int n, p, flen, idle, b, pos;
    bit in_frame, glitch, ok;
    in_frame = 0;
    idle = 0;
    n = 0; p = 1; flen = 1; glitch = 0; val = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_frame = 0;
        idle = 0;
        continue;
      end
      if (!in_frame) begin
        if (tx_w[k] == 1'b0) begin
          in_frame = 1;
          n = 0;
          p = int'(div_r[k]) + 1;
          flen = frame_bits(k) * p;
          glitch = 0;
          val = '0;
          if (seen[k]) gap_sum[k] += idle;
          seen[k] = 1;
          start_cyc[k] = cyc;
        end else begin
          idle++;
        end
      end
      if (in_frame) begin
        b = n / p;
        if (n % p == 0) val[b] = tx_w[k];
        else if (tx_w[k] !== val[b]) glitch = 1;
        n++;
        if (n == flen) begin
          in_frame = 0;
          idle = 0;
          mon_frames[k]++;
          ch = '0;
          for (int i = 0; i < DB[k]; i++) ch[i] = val[1+i];
          ok = !glitch && (val[0] == 1'b0);
          pos = 1 + DB[k];
          if (PAR[k] != 0) begin
            if (val[pos] !== ((^ch) ^ (PAR[k] == 1))) ok = 0;
            pos++;
          end
          for (int s = 0; s < STOP[k]; s++) if (val[pos+s] !== 1'b1) ok = 0;
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL frame%0d: got char %0h, expected no frame", k, ch);
          end else begin
            e = exp_q.pop_front();
            if (!ok || e !== {2'(k), ch}) begin
              n_fail++;
              $display("FAIL frame%0d: got char %0h (format ok=%0d) expected %0h", k, ch, ok, e[8:0]);
            end
          end
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);
  initial monitor(2);

  // FIFO level / ready watch for the streaming test on instance 0
  always @(negedge clk) begin
    if (track) begin
      if (lvl0 > 3'd4) lvl_viol++;
      if (lvl0 == 3'd4 && tready_w[0]) lvl_viol++;
      if (lvl0 < 3'd4 && !tready_w[0]) lvl_viol++;
      if (lvl0 == 3'd4 && !tready_w[0]) full_seen = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  // Offers one character; records the handshake edge and the model's output
  task automatic send(input int k, input logic [8:0] d, input logic last, input bit hold);
    int w;
    w = 0;
    @(negedge clk);
    tdata_r[k]  = d;
    tlast_r[k]  = last;
    tvalid_r[k] = 1'b1;
    while (tready_w[k] !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout%0d: tready stayed %0b, required 1", k, tready_w[k]);
      tvalid_r[k] = 1'b0;
      return;
    end
    hs_cyc = cyc + 1;
    exp_q.push_back({2'(k), d});
    if (EOL_ON[k] != 0 && last) exp_q.push_back({2'(k), 9'h00A});
    @(posedge clk);
    if (!hold) begin
      #1;
      tvalid_r[k] = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while ((busy_w != 3'b000 || exp_q.size() != 0) && c < 3000);
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy_w != 3'b000 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_%s: busy %b, %0d frames outstanding, required 0", tag, busy_w, exp_q.size());
    end
  endtask

  // Sends one character and compares the exact line waveform sample by sample
  task automatic check_frame(input int k, input logic [8:0] d, input int div,
                             input logic [15:0] bits, input int nb, input string name);
    logic [127:0] got, exp;
    int len, c;
    div_r[k] = 16'(div);
    send(k, d, 1'b0, 1'b0);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (tx_w[k] !== 1'b0 && c < 20);
    chk({name, "_latency"}, 32'(cyc - hs_cyc), 32'd2);
    len = nb * (div + 1) + 3;
    got = '0;
    exp = '0;
    for (int i = 0; i < len; i++) begin
      got[i] = tx_w[k];
      exp[i] = (i < nb * (div + 1)) ? bits[i / (div + 1)] : 1'b1;
      if (i != len - 1) @(negedge clk);
    end
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s_wave: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- test sequence ----------------
  typedef struct {
    int          k;
    logic [8:0]  data;
    int          div;
    logic [15:0] bits;   // line bits, start bit first (LSB)
    int          nb;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int bc, fa, f0, f1, c;
    logic [8:0] d;

    vecs[0] = '{k:0, data:9'h055, div:3, bits:16'({1'b1, 8'h55, 1'b0}), nb:10};
    vecs[1] = '{k:0, data:9'h0A3, div:1, bits:16'({1'b1, 8'hA3, 1'b0}), nb:10};
    vecs[2] = '{k:1, data:9'h041, div:2, bits:16'({1'b1, 1'b0, 7'h41, 1'b0}), nb:10};
    vecs[3] = '{k:2, data:9'h041, div:1, bits:16'({2'b11, 1'b1, 7'h41, 1'b0}), nb:11};
    vecs[4] = '{k:1, data:9'h007, div:0, bits:16'({1'b1, 1'b1, 7'h07, 1'b0}), nb:10};
    vecs[5] = '{k:2, data:9'h000, div:0, bits:16'({2'b11, 1'b1, 7'h00, 1'b0}), nb:11};
    vecs[6] = '{k:0, data:9'h0FF, div:0, bits:16'({1'b1, 8'hFF, 1'b0}), nb:10};
    vecs[7] = '{k:2, data:9'h07F, div:2, bits:16'({2'b11, 1'b0, 7'h7F, 1'b0}), nb:11};
    vecs[8] = '{k:1, data:9'h07F, div:1, bits:16'({1'b1, 1'b1, 7'h7F, 1'b0}), nb:10};
    vecs[9] = '{k:0, data:9'h000, div:2, bits:16'({1'b1, 8'h00, 1'b0}), nb:10};

    for (int k = 0; k < 3; k++) begin
      tdata_r[k] = '0;
      div_r[k]   = 16'd3;
    end
    tlast_r  = '0;
    tvalid_r = '0;

    // Reset state, applied without any clock edge
    #1 rst_n = 1'b0;
    #2;
    chk("rst_tx", 32'(tx_w), 32'h7);
    chk("rst_busy", 32'(busy_w), 32'h0);
    chk("rst_level", {20'd0, 1'b0, lvl0, lvl1, lvl2, 2'b00}, 32'h0);
    chk("rst_ready", 32'(tready_w), 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 chk("ready_after_release", 32'(tready_w), 32'h7);

    // 8N1, divisor 3, 0x55: busy lasts exactly one 40-clock frame
    div_r[0] = 16'd3;
    send(0, 9'h055, 1'b0, 1'b0);
    bc = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (busy_w[0]) bc++;
    end
    chk("busy_len", 32'(bc), 32'd40);
    wait_idle("t1");

    // Table of single frames with exact line waveforms
    for (int i = 0; i < 10; i++) begin
      check_frame(vecs[i].k, vecs[i].data, vecs[i].div, vecs[i].bits, vecs[i].nb,
                  $sformatf("vec%0d", i));
      wait_idle($sformatf("vec%0d", i));
    end

    // Streaming into a 4-deep FIFO, divisor 0: back-to-back frames, no gaps
    div_r[0] = 16'd0;
    seen[0] = 0;
    gap_sum[0] = 0;
    f0 = mon_frames[0];
    lvl_viol = 0;
    full_seen = 0;
    track = 1'b1;
    for (int i = 0; i < 10; i++) send(0, 9'(8'h30 + 8'(i * 7)), 1'b0, i < 9);
    wait_idle("stream");
    track = 1'b0;
    chk("stream_frames", 32'(mon_frames[0] - f0), 32'd10);
    chk("stream_gaps", 32'(gap_sum[0]), 32'd0);
    chk("stream_level_ready", 32'(lvl_viol), 32'd0);
    chk("stream_full_seen", 32'(full_seen), 32'd1);

    // EOL injection on tlast (k=1) versus no injection (k=0)
    div_r[1] = 16'd1;
    seen[1] = 0;
    gap_sum[1] = 0;
    f1 = mon_frames[1];
    send(1, 9'h031, 1'b1, 1'b1);
    send(1, 9'h032, 1'b0, 1'b0);
    wait_idle("eol");
    chk("eol_frames", 32'(mon_frames[1] - f1), 32'd3);
    chk("eol_gaps", 32'(gap_sum[1]), 32'd0);
    div_r[0] = 16'd1;
    f0 = mon_frames[0];
    send(0, 9'h031, 1'b1, 1'b1);
    send(0, 9'h032, 1'b0, 1'b0);
    wait_idle("noeol");
    chk("noeol_frames", 32'(mon_frames[0] - f0), 32'd2);

    // Divisor change mid-frame only affects the following frame
    div_r[0] = 16'd3;
    send(0, 9'h0A5, 1'b0, 1'b1);
    send(0, 9'h00F, 1'b0, 1'b0);
    c = 0;
    while (tx_w[0] !== 1'b0 && c < 20) begin
      @(negedge clk);
      c++;
    end
    fa = cyc;
    repeat (10) @(negedge clk);
    div_r[0] = 16'd1;
    c = 0;
    while (busy_w[0] && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("div_change_busy_end", 32'(cyc - fa), 32'd59);
    chk("div_change_second_start", 32'(start_cyc[0] - fa), 32'd40);
    wait_idle("divchg");

    // Reset in the third data bit with characters still queued
    div_r[0] = 16'd3;
    send(0, 9'h0C5, 1'b0, 1'b1);
    send(0, 9'h011, 1'b0, 1'b1);
    send(0, 9'h022, 1'b0, 1'b0);
    c = 0;
    while (tx_w[0] !== 1'b0 && c < 20) begin
      @(negedge clk);
      c++;
    end
    fa = cyc;
    while (cyc < fa + 13) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_tx", 32'(tx_w[0]), 32'd1);
    chk("midrst_busy", 32'(busy_w[0]), 32'd0);
    chk("midrst_level", 32'(lvl0), 32'd0);
    chk("midrst_ready", 32'(tready_w[0]), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    #1 chk("release_ready_pre_edge", 32'(tready_w[0]), 32'd0);
    @(posedge clk);
    #1 chk("release_ready", 32'(tready_w[0]), 32'd1);
    check_frame(0, 9'h0B7, 2, 16'({1'b1, 8'hB7, 1'b0}), 10, "post_reset");
    wait_idle("post_reset");

    // Randomized bursts against the frame model
    for (int r = 0; r < 12; r++) begin
      int k, n;
      k = $urandom_range(0, 2);
      n = $urandom_range(1, 8);
      div_r[k] = 16'($urandom_range(0, 3));
      for (int i = 0; i < n; i++) begin
        d = 9'($urandom) & 9'((1 << DB[k]) - 1);
        send(k, d, 1'($urandom_range(0, 1)), (i < n - 1) && ($urandom_range(0, 3) != 0));
      end
      wait_idle($sformatf("rand%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
